// File: rtl/mc_core.sv
// mc_core: multicycle execution engine for the 6/5/5/5/11 instruction format.
// One instruction at a time walks FETCH -> DECODE -> EXEC -> [MEM] -> [WB].
// Each instruction finishes before the next fetch, so operand reads never
// need forwarding. A host port loads and inspects imem, dmem and the register
// file while the core is not busy.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | out of reset, waiting for start
// S_FETCH  | latch IMEM[pc] into the instruction register
// S_DECODE | read R[s1], R[s2] into the operand registers
// S_EXEC   | ALU / effective address / branch resolve / halt or trap
// S_MEM    | LW reads the data word, SW writes it
// S_WB     | register write, pc+1
// S_HALT   | program finished (HALT or illegal opcode), waiting for start

module mc_core #(
   parameter int DATA_W     = 32,
   parameter int IMEM_DEPTH = 32,
   parameter int DMEM_DEPTH = 32,
   parameter int HOST_AW    = 10
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic                          start,
   input  logic                          host_we,
   input  logic [1:0]                    host_space,
   input  logic [HOST_AW-1:0]            host_addr,
   input  logic [DATA_W-1:0]             host_wdata,
   output logic [DATA_W-1:0]             host_rdata,
   output logic                          busy,
   output logic                          done,
   output logic                          error,
   output logic [$clog2(IMEM_DEPTH)-1:0] pc,
   output logic [31:0]                   instr_count
);

   localparam int PC_W = $clog2(IMEM_DEPTH);
   localparam int DA_W = $clog2(DMEM_DEPTH);

   localparam logic [5:0] OP_NOP   = 6'b000000;
   localparam logic [5:0] OP_ADDU  = 6'b000001;
   localparam logic [5:0] OP_BEQ   = 6'b000010;
   localparam logic [5:0] OP_LW    = 6'b000011;
   localparam logic [5:0] OP_MUL   = 6'b000100;
   localparam logic [5:0] OP_ADDIU = 6'b000101;
   localparam logic [5:0] OP_SW    = 6'b000110;
   localparam logic [5:0] OP_J     = 6'b000111;
   localparam logic [5:0] OP_HALT  = 6'b001000;

   localparam logic [1:0] SP_IMEM = 2'b00;
   localparam logic [1:0] SP_DMEM = 2'b01;
   localparam logic [1:0] SP_REGS = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_t;

   state_t              state;
   logic [31:0]         ir;
   logic [DATA_W-1:0]   opa;
   logic [DATA_W-1:0]   opb;
   logic [DATA_W-1:0]   res;
   logic [DA_W-1:0]     maddr;

   logic [31:0]         imem [IMEM_DEPTH];
   logic [DATA_W-1:0]   dmem [DMEM_DEPTH];
   logic [DATA_W-1:0]   rf   [32];

   logic [5:0]          f_op;
   logic [4:0]          f_s1;
   logic [4:0]          f_s2;
   logic [4:0]          f_d;
   logic [DATA_W-1:0]   mag;
   logic [DATA_W-1:0]   simm;
   logic [DATA_W-1:0]   ea;
   logic [DATA_W-1:0]   sum;
   logic [DATA_W-1:0]   prod;
   logic [PC_W-1:0]     pc_inc;
   logic [PC_W-1:0]     pc_tgt;
   logic [4:0]          wb_addr;
   logic                wb_en;
   logic                sw_en;
   logic                host_ok;
   logic [31:0]         host_w32;
   logic                unused_bits;

   assign f_op = ir[31:26];
   assign f_s1 = ir[25:21];
   assign f_s2 = ir[20:16];
   assign f_d  = ir[15:11];

   // Sign-magnitude immediate: imm[10] is the sign, imm[9:0] the magnitude.
   assign mag    = DATA_W'(ir[9:0]);
   assign simm   = ir[10] ? (~mag + 1'b1) : mag;
   assign ea     = opa + simm;
   assign sum    = opa + opb;
   assign prod   = opa * opb;
   assign pc_inc = pc + PC_W'(1);
   assign pc_tgt = ir[PC_W-1:0];

   // ADDU/MUL write d; ADDIU/LW write s2.
   assign wb_addr  = (f_op == OP_ADDU || f_op == OP_MUL) ? f_d : f_s2;
   assign wb_en    = (state == S_WB) && (wb_addr != 5'd0);
   assign sw_en    = (state == S_MEM) && (f_op == OP_SW);
   assign host_ok  = host_we && !busy;
   assign host_w32 = 32'(host_wdata);

   assign unused_bits = ^{host_addr, ea, ir};

   function automatic logic [DATA_W-1:0] rf_rd(input logic [4:0] idx);
      return (idx == 5'd0) ? '0 : rf[idx];
   endfunction

   // Sequencer: state, pc, counters and the datapath pipeline registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         error       <= 1'b0;
         pc          <= '0;
         instr_count <= '0;
         ir          <= '0;
         opa         <= '0;
         opb         <= '0;
         res         <= '0;
         maddr       <= '0;
      end else begin
         case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  state       <= S_FETCH;
                  busy        <= 1'b1;
                  done        <= 1'b0;
                  error       <= 1'b0;
                  pc          <= '0;
                  instr_count <= '0;
               end
            end
            S_FETCH: begin
               ir    <= imem[pc];
               state <= S_DECODE;
            end
            S_DECODE: begin
               opa   <= rf_rd(f_s1);
               opb   <= rf_rd(f_s2);
               state <= S_EXEC;
            end
            S_EXEC: begin
               case (f_op)
                  OP_NOP: begin
                     pc          <= pc_inc;
                     instr_count <= instr_count + 32'd1;
                     state       <= S_FETCH;
                  end
                  OP_ADDU: begin
                     res   <= sum;
                     state <= S_WB;
                  end
                  OP_MUL: begin
                     res   <= prod;
                     state <= S_WB;
                  end
                  OP_ADDIU: begin
                     res   <= ea;
                     state <= S_WB;
                  end
                  OP_BEQ: begin
                     pc          <= (opa == opb) ? pc_tgt : pc_inc;
                     instr_count <= instr_count + 32'd1;
                     state       <= S_FETCH;
                  end
                  OP_J: begin
                     pc          <= pc_tgt;
                     instr_count <= instr_count + 32'd1;
                     state       <= S_FETCH;
                  end
                  OP_LW, OP_SW: begin
                     maddr <= ea[DA_W-1:0];
                     state <= S_MEM;
                  end
                  OP_HALT: begin
                     instr_count <= instr_count + 32'd1;
                     busy        <= 1'b0;
                     done        <= 1'b1;
                     state       <= S_HALT;
                  end
                  default: begin
                     // Trap leaves pc on the offending instruction and does not retire it.
                     error <= 1'b1;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     state <= S_HALT;
                  end
               endcase
            end
            S_MEM: begin
               if (f_op == OP_LW) begin
                  res   <= dmem[maddr];
                  state <= S_WB;
               end else begin
                  pc          <= pc_inc;
                  instr_count <= instr_count + 32'd1;
                  state       <= S_FETCH;
               end
            end
            S_WB: begin
               pc          <= pc_inc;
               instr_count <= instr_count + 32'd1;
               state       <= S_FETCH;
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
               done  <= 1'b0;
            end
         endcase
      end
   end

   // Register file: core writeback, else host write when idle; R0 is never written.
   always_ff @(posedge clock) begin
      if (wb_en)
         rf[wb_addr] <= res;
      else if (host_ok && host_space == SP_REGS && host_addr[4:0] != 5'd0)
         rf[host_addr[4:0]] <= host_wdata;
   end

   // Data memory: SW in MEM, else host write when idle.
   always_ff @(posedge clock) begin
      if (sw_en)
         dmem[maddr] <= opb;
      else if (host_ok && host_space == SP_DMEM)
         dmem[host_addr[DA_W-1:0]] <= host_wdata;
   end

   // Instruction memory: host-loaded only.
   always_ff @(posedge clock) begin
      if (host_ok && host_space == SP_IMEM)
         imem[host_addr[PC_W-1:0]] <= host_w32;
   end

   // Host inspect port: combinational read of the selected space.
   always_comb begin
      host_rdata = '0;
      case (host_space)
         SP_IMEM: host_rdata = DATA_W'(imem[host_addr[PC_W-1:0]]);
         SP_DMEM: host_rdata = dmem[host_addr[DA_W-1:0]];
         SP_REGS: host_rdata = rf_rd(host_addr[4:0]);
         default: host_rdata = '0;
      endcase
   end

endmodule

// File: tb/tb_mc_core.sv
// Directed bench for mc_core with hand-computed expectations.
module tb_mc_core;

   logic        clock = 1'b0;
   logic        reset_n = 1'b1;
   logic        start = 1'b0;
   logic        host_we = 1'b0;
   logic [1:0]  host_space = 2'b11;
   logic [9:0]  host_addr = '0;
   logic [31:0] host_wdata = '0;
   logic [31:0] host_rdata;
   logic        busy;
   logic        done;
   logic        error;
   logic [4:0]  pc;
   logic [31:0] instr_count;

   int n_vec = 0;
   int n_err = 0;

   mc_core #(.DATA_W(32), .IMEM_DEPTH(32), .DMEM_DEPTH(32), .HOST_AW(10)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .host_we     (host_we),
      .host_space  (host_space),
      .host_addr   (host_addr),
      .host_wdata  (host_wdata),
      .host_rdata  (host_rdata),
      .busy        (busy),
      .done        (done),
      .error       (error),
      .pc          (pc),
      .instr_count (instr_count)
   );

   always #5 clock = ~clock;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] enc(input logic [5:0] op, input logic [4:0] s1,
                                       input logic [4:0] s2, input logic [4:0] d,
                                       input logic [10:0] imm);
      return {op, s1, s2, d, imm};
   endfunction

   task automatic hwrite(input logic [1:0] sp, input logic [9:0] a, input logic [31:0] d);
      @(negedge clock);
      host_space = sp;
      host_addr  = a;
      host_wdata = d;
      host_we    = 1'b1;
      @(posedge clock);
      #1 host_we = 1'b0;
   endtask

   task automatic hread(input logic [1:0] sp, input logic [9:0] a, output logic [31:0] d);
      host_space = sp;
      host_addr  = a;
      #1 d = host_rdata;
   endtask

   task automatic do_start();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      #1 start = 1'b0;
   endtask

   // Counts edges after the start edge until done is seen.
   task automatic wait_done(output int cyc);
      cyc = 0;
      while (cyc < 5000) begin
         @(negedge clock);
         if (done) break;
         @(posedge clock);
         cyc++;
      end
      chk("run_done", {31'd0, done}, 32'd1);
   endtask

   initial begin
      int          cyc;
      logic [31:0] v;

      // Reset values
      #2 reset_n = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_error", {31'd0, error}, 32'd0);
      chk("rst_pc", {27'd0, pc}, 32'd0);
      chk("rst_icount", instr_count, 32'd0);
      reset_n = 1'b1;

      // HALT alone: 3 cycles, done after its EXEC
      hwrite(2'b00, 10'd0, enc(6'd8, 5'd0, 5'd0, 5'd0, 11'd0));
      do_start();
      wait_done(cyc);
      chk("halt_cycles", cyc, 32'd3);
      chk("halt_icount", instr_count, 32'd1);
      chk("halt_busy", {31'd0, busy}, 32'd0);

      // Dot product {1,2,3}.{4,5,6}
      hwrite(2'b00, 10'd0,  enc(6'd1, 5'd0, 5'd0, 5'd1, 11'd0));
      hwrite(2'b00, 10'd1,  enc(6'd2, 5'd7, 5'd0, 5'd0, 11'd10));
      hwrite(2'b00, 10'd2,  enc(6'd3, 5'd3, 5'd2, 5'd0, 11'd0));
      hwrite(2'b00, 10'd3,  enc(6'd3, 5'd5, 5'd4, 5'd0, 11'd0));
      hwrite(2'b00, 10'd4,  enc(6'd4, 5'd2, 5'd4, 5'd2, 11'd0));
      hwrite(2'b00, 10'd5,  enc(6'd1, 5'd1, 5'd2, 5'd1, 11'd0));
      hwrite(2'b00, 10'd6,  enc(6'd5, 5'd3, 5'd3, 5'd0, 11'd1));
      hwrite(2'b00, 10'd7,  enc(6'd5, 5'd5, 5'd5, 5'd0, 11'd1));
      hwrite(2'b00, 10'd8,  enc(6'd5, 5'd7, 5'd7, 5'd0, 11'h401));
      hwrite(2'b00, 10'd9,  enc(6'd7, 5'd0, 5'd0, 5'd0, 11'd1));
      hwrite(2'b00, 10'd10, enc(6'd8, 5'd0, 5'd0, 5'd0, 11'd0));
      for (int i = 0; i < 3; i++) begin
         hwrite(2'b01, 10'(i), 32'(i + 1));
         hwrite(2'b01, 10'(i + 8), 32'(i + 4));
      end
      hwrite(2'b10, 10'd3, 32'd0);
      hwrite(2'b10, 10'd5, 32'd8);
      hwrite(2'b10, 10'd7, 32'd3);
      hwrite(2'b10, 10'd1, 32'hDEAD_BEEF);
      do_start();
      wait_done(cyc);
      // 4 + 3*(3+5+5+4+4+4+4+4+3) + 3 + 3
      chk("dot_cycles", cyc, 32'd118);
      chk("dot_error", {31'd0, error}, 32'd0);
      chk("dot_icount", instr_count, 32'd30);
      hread(2'b10, 10'd1, v); chk("dot_r1", v, 32'd32);
      hread(2'b10, 10'd7, v); chk("dot_r7", v, 32'd0);
      hread(2'b10, 10'd3, v); chk("dot_r3", v, 32'd3);
      hread(2'b10, 10'd5, v); chk("dot_r5", v, 32'd11);

      // SW/LW address wrap and negative immediate
      hwrite(2'b10, 10'd1, 32'd30);
      hwrite(2'b10, 10'd2, 32'h0000_00A5);
      hwrite(2'b10, 10'd4, 32'd0);
      hwrite(2'b10, 10'd6, 32'd0);
      hwrite(2'b00, 10'd0, enc(6'd6, 5'd1, 5'd2, 5'd0, 11'd5));
      hwrite(2'b00, 10'd1, enc(6'd3, 5'd0, 5'd4, 5'd0, 11'd3));
      hwrite(2'b00, 10'd2, enc(6'd5, 5'd0, 5'd6, 5'd0, 11'h402));
      hwrite(2'b00, 10'd3, enc(6'd8, 5'd0, 5'd0, 5'd0, 11'd0));
      do_start();
      wait_done(cyc);
      chk("wrap_cycles", cyc, 32'd16);
      chk("wrap_icount", instr_count, 32'd4);
      hread(2'b01, 10'd3, v); chk("wrap_d3", v, 32'h0000_00A5);
      hread(2'b10, 10'd4, v); chk("wrap_r4", v, 32'h0000_00A5);
      hread(2'b10, 10'd6, v); chk("wrap_r6", v, 32'hFFFF_FFFE);

      // Illegal opcode trap at PC 2
      hwrite(2'b00, 10'd0, 32'd0);
      hwrite(2'b00, 10'd1, enc(6'd5, 5'd0, 5'd1, 5'd0, 11'd1));
      hwrite(2'b00, 10'd2, 32'hFC00_0000);
      do_start();
      wait_done(cyc);
      chk("ill_cycles", cyc, 32'd10);
      chk("ill_error", {31'd0, error}, 32'd1);
      chk("ill_done", {31'd0, done}, 32'd1);
      chk("ill_pc", {27'd0, pc}, 32'd2);
      chk("ill_icount", instr_count, 32'd2);
      hwrite(2'b00, 10'd2, enc(6'd8, 5'd0, 5'd0, 5'd0, 11'd0));
      do_start();
      @(negedge clock);
      chk("restart_error", {31'd0, error}, 32'd0);
      chk("restart_busy", {31'd0, busy}, 32'd1);
      chk("restart_icount", instr_count, 32'd0);
      wait_done(cyc);
      chk("restart_error_end", {31'd0, error}, 32'd0);
      chk("restart_icount_end", instr_count, 32'd3);

      // R0 protection
      hwrite(2'b10, 10'd1, 32'd7);
      hwrite(2'b10, 10'd0, 32'h0000_1234);
      hread(2'b10, 10'd0, v); chk("r0_host", v, 32'd0);
      hwrite(2'b00, 10'd0, enc(6'd1, 5'd1, 5'd1, 5'd0, 11'd0));
      hwrite(2'b00, 10'd1, enc(6'd8, 5'd0, 5'd0, 5'd0, 11'd0));
      do_start();
      wait_done(cyc);
      hread(2'b10, 10'd0, v); chk("r0_core", v, 32'd0);
      chk("r0_icount", instr_count, 32'd2);

      // MUL wrap; start held and host writes attempted while busy
      hwrite(2'b10, 10'd1, 32'hFFFF_FFFF);
      hwrite(2'b10, 10'd2, 32'd2);
      hwrite(2'b10, 10'd3, 32'd0);
      hwrite(2'b10, 10'd5, 32'h11);
      hwrite(2'b00, 10'd0, enc(6'd4, 5'd1, 5'd2, 5'd3, 11'd0));
      hwrite(2'b00, 10'd1, enc(6'd8, 5'd0, 5'd0, 5'd0, 11'd0));
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      cyc = 0;
      repeat (5) begin
         @(negedge clock);
         host_space = 2'b10;
         host_addr  = 10'd5;
         host_wdata = 32'h55;
         host_we    = 1'b1;
         @(posedge clock);
         cyc++;
      end
      @(negedge clock);
      start   = 1'b0;
      host_we = 1'b0;
      while (cyc < 500) begin
         if (done) break;
         @(posedge clock);
         cyc++;
         @(negedge clock);
      end
      chk("mul_done", {31'd0, done}, 32'd1);
      chk("mul_cycles", cyc, 32'd7);
      chk("mul_icount", instr_count, 32'd2);
      hread(2'b10, 10'd3, v); chk("mul_r3", v, 32'hFFFF_FFFE);
      hread(2'b10, 10'd5, v); chk("busy_hostwr", v, 32'h11);

      // Reset during the MEM state of an LW
      hwrite(2'b10, 10'd4, 32'h77);
      hwrite(2'b01, 10'd0, 32'h99);
      hwrite(2'b00, 10'd0, enc(6'd3, 5'd0, 5'd4, 5'd0, 11'd0));
      hwrite(2'b00, 10'd1, enc(6'd8, 5'd0, 5'd0, 5'd0, 11'd0));
      do_start();
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset_n = 1'b0;
      @(posedge clock);
      #1;
      chk("rstmid_busy", {31'd0, busy}, 32'd0);
      chk("rstmid_done", {31'd0, done}, 32'd0);
      chk("rstmid_pc", {27'd0, pc}, 32'd0);
      @(negedge clock);
      reset_n = 1'b1;
      hread(2'b10, 10'd4, v); chk("rstmid_r4", v, 32'h77);
      hwrite(2'b10, 10'd4, 32'h12);
      hread(2'b10, 10'd4, v); chk("rstmid_hostwr", v, 32'h12);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
